inv_sub_bytes_iter: RTL and testbench

Iterative inverse SubBytes stage for the AES-128 decryption datapath. Accepts a 128-bit state over a valid/ready handshake. Substitutes all 16 bytes through `LANES` parallel inverse S-box lookups, working over several cycles. Presents the result on a second valid/ready handshake. It sits between inverse ShiftRows (upstream) and AddRoundKey (downstream), trading latency for fewer inverse S-box instances.

---
 rtl/inv_sub_bytes_iter.sv | 116 +++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_iter
// Purpose  : Iterative AES inverse SubBytes, LANES inverse S-boxes per cycle.
// Revision : 1.0
// ============================================================================
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N      = 16 / LANES;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

  // FIPS-197 inverse S-box, entry 0 in the most significant byte
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  state_t             fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       st_q, st_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [LANES*8-1:0] lane_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] lane_in;
    assign lane_in = st_q[127 - 8*(int'(cnt_q)*LANES + l) -: 8];
    assign lane_out[8*l +: 8] = inv_sbox(lane_in);
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in_state;
          cnt_d = '0;
          fsm_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          st_d[127 - 8*(int'(cnt_q)*LANES + l) -: 8] = lane_out[8*l +: 8];
        end
        if (cnt_q == LAST_CHUNK) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Leaving DONE always passes through IDLE, so no same-cycle re-accept.
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = st_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
// Testbench for inv_sub_bytes_iter: five instances (LANES = 1,2,4,8,16) checked
// against an inverse S-box derived independently from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         out_ready = 1'b1;
  logic [127:0] in_state = '0;
  logic         in_valid_v [5];
  wire          in_ready_v [5];
  wire          out_valid_v [5];
  wire          busy_v [5];
  wire  [127:0] out_state_v [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_state  (in_state),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_state (out_state_v[g]),
      .busy      (busy_v[g])
    );
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t         vt [20];
  logic [7:0]   isb [256];
  logic [127:0] sb [$];
  int           n_chk = 0;
  int           n_pass = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = isb[s[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Waits for in_ready, presents one block, pushes its expected result.
  task automatic send(input int idx, input logic [127:0] data, input logic [127:0] exp,
                      input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready_v[idx] && g < 64) begin
      @(negedge clk);
      g++;
    end
    check($sformatf("%s ready", name), 128'(in_ready_v[idx]), 128'd1);
    in_state = data;
    in_valid_v[idx] = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    in_valid_v[idx] = 1'b0;
    in_state = rnd128();
  endtask

  // Called at the negedge after the accept edge; lat counts edges since accept.
  task automatic collect(input int idx, input int exp_lat, input string name);
    int lat;
    logic [127:0] e;
    lat = 0;
    while (!out_valid_v[idx] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s latency", name), 128'(lat), 128'(exp_lat));
    e = (sb.size() > 0) ? sb.pop_front() : 'x;
    check($sformatf("%s data", name), out_state_v[idx], e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, ea, d;
    int last, n_acc, seen;
    logic chg;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
    for (int i = 0; i < 5; i++) in_valid_v[i] = 1'b0;

    vt[0] = '{128'h0, {16{8'h52}}};
    vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
    vt[2] = '{{16{8'h63}}, 128'h0};
    vt[3] = '{{16{8'hff}}, {16{8'h7d}}};
    for (int bk = 0; bk < 16; bk++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(bk*16 + k);
      vt[4+bk] = '{d, inv_sub(d)};
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst in_ready L%0d", 1 << i), 128'(in_ready_v[i]), 128'd0);
      check($sformatf("rst out_valid L%0d", 1 << i), 128'(out_valid_v[i]), 128'd0);
      check($sformatf("rst busy L%0d", 1 << i), 128'(busy_v[i]), 128'd0);
      check($sformatf("rst out_state L%0d", 1 << i), out_state_v[i], 128'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("post-rst in_ready L%0d", 1 << i), 128'(in_ready_v[i]), 128'd1);

    // Vector table on every lane count
    for (int idx = 0; idx < 5; idx++) begin
      for (int i = 0; i < 20; i++) begin
        send(idx, vt[i].din, vt[i].dexp, $sformatf("L%0d v%0d", 1 << idx, i));
        collect(idx, 16 >> idx, $sformatf("L%0d v%0d", 1 << idx, i));
        @(negedge clk);
        check($sformatf("L%0d v%0d pulse", 1 << idx, i), 128'(out_valid_v[idx]), 128'd0);
      end
    end

    // Backpressure with a competing block waiting upstream
    a = 128'h00112233445566778899aabbccddeeff;
    b = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    ea = inv_sub(a);
    out_ready = 1'b0;
    send(2, a, ea, "bp A");
    collect(2, 4, "bp A");
    in_state = b;
    in_valid_v[2] = 1'b1;
    sb.push_back(inv_sub(b));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp hold state %0d", i), out_state_v[2], ea);
      check($sformatf("bp hold valid %0d", i), 128'(out_valid_v[2]), 128'd1);
      check($sformatf("bp hold in_ready %0d", i), 128'(in_ready_v[2]), 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp idle in_ready", 128'(in_ready_v[2]), 128'd1);
    check("bp idle out_valid", 128'(out_valid_v[2]), 128'd0);
    check("bp idle busy", 128'(busy_v[2]), 128'd0);
    @(negedge clk);
    check("bp B accepted busy", 128'(busy_v[2]), 128'd1);
    in_valid_v[2] = 1'b0;
    in_state = rnd128();
    collect(2, 4, "bp B");

    // Reset asserted while chunk 2 is being processed
    send(2, rnd128(), 128'h0, "rst-run");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid-rst out_valid", 128'(out_valid_v[2]), 128'd0);
    check("mid-rst busy", 128'(busy_v[2]), 128'd0);
    check("mid-rst in_ready", 128'(in_ready_v[2]), 128'd1);
    check("mid-rst out_state", out_state_v[2], 128'd0);
    sb.delete();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_v[2]) seen++;
    end
    check("aborted block no output", 128'(seen), 128'd0);
    send(2, {16{8'h63}}, 128'h0, "after rst");
    collect(2, 4, "after rst");

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    @(negedge clk);
    in_state = rnd128();
    in_valid_v[2] = 1'b1;
    #1;
    last = -1; n_acc = 0; chg = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (chg) begin
        in_state = rnd128();
        chg = 1'b0;
      end
      if (out_valid_v[2]) begin
        d = (sb.size() > 0) ? sb.pop_front() : 'x;
        check($sformatf("b2b data @%0d", i), out_state_v[2], d);
      end
      if (in_ready_v[2]) begin
        if (last >= 0) check($sformatf("b2b spacing @%0d", i), 128'(i - last), 128'd6);
        last = i;
        n_acc++;
        sb.push_back(inv_sub(in_state));
        chg = 1'b1;
      end
      @(negedge clk);
    end
    in_valid_v[2] = 1'b0;
    check("b2b accept count", 128'(n_acc >= 6), 128'd1);
    for (int i = 0; i < 12 && sb.size() > 0; i++) begin
      if (out_valid_v[2]) begin
        d = sb.pop_front();
        check("b2b drain data", out_state_v[2], d);
      end
      @(negedge clk);
    end
    check("scoreboard empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
